// File: rtl/audio_stream_transceiver.sv
// Multi-channel SPI-style PCM receiver, frame FIFO, per-frame mute/attenuation
// and I2S-style serial transmitter, all on a single serial clock.

// Per-channel sample processing: mute or arithmetic right shift.
module audio_chan_proc #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] sample,
  input  logic             mute,
  input  logic [3:0]       attenuation,
  output logic [WIDTH-1:0] result
);
  logic signed [WIDTH-1:0] s;
  logic [3:0]              sh;

  assign s = sample;

  // Clamp the shift so full attenuation leaves only the sign bits.
  always_comb begin
    sh = attenuation;
    if (int'(attenuation) > WIDTH-1) sh = 4'(WIDTH-1);
    result = '0;
    if (!mute) result = s >>> sh;
  end
endmodule

module audio_stream_transceiver #(
  parameter  int WIDTH     = 16,
  parameter  int CHANNELS  = 2,
  parameter  int SLOT_BITS = 32,
  parameter  int DEPTH     = 4,
  localparam int TOTAL     = CHANNELS*SLOT_BITS,
  localparam int BNW       = $clog2(TOTAL),
  localparam int LVW       = $clog2(DEPTH+1)
) (
  input  logic           serial_clk,
  input  logic           reset,
  input  logic           spi_chip_select,
  input  logic           spi_mosi,
  input  logic           mute,
  input  logic [3:0]     attenuation,
  input  logic           clear_flags,
  output logic           i2s_ws,
  output logic           i2s_sound_bit_out,
  output logic [BNW-1:0] i2s_bit_number,
  output logic [LVW-1:0] fifo_level,
  output logic           overflow,
  output logic           underflow
);
  localparam int FB  = CHANNELS*WIDTH;
  localparam int AW  = $clog2(DEPTH);
  localparam int RCW = $clog2(FB+2);
  localparam int SW  = $clog2(SLOT_BITS);
  localparam int KW  = $clog2(CHANNELS);
  localparam int IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // ---------------- receiver ----------------
  // rx_cnt saturates at FB+1: FB marks "frame complete, push now", FB+1 marks
  // "already pushed, ignore further bits until cs rises".
  logic [RCW-1:0] rx_cnt;
  logic [FB-1:0]  rx_sr;
  logic           push;

  // Shift serial bits in while selected; cs high discards any partial frame.
  always_ff @(posedge serial_clk or negedge reset) begin
    if (!reset) begin
      rx_cnt <= '0;
      rx_sr  <= '0;
    end else if (spi_chip_select) begin
      rx_cnt <= '0;
    end else begin
      if (rx_cnt < RCW'(FB))  rx_sr  <= {rx_sr[FB-2:0], spi_mosi};
      if (rx_cnt <= RCW'(FB)) rx_cnt <= rx_cnt + RCW'(1);
    end
  end

  assign push = (rx_cnt == RCW'(FB));

  // ---------------- FIFO ----------------
  logic [FB-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, load, pop, push_ok;

  assign full    = (fifo_level == LVW'(DEPTH));
  assign empty   = (fifo_level == '0);
  assign load    = (i2s_bit_number == BNW'(TOTAL-1));
  assign pop     = load & ~empty;
  // A pop in the same cycle frees the slot, so a push while full still fits.
  assign push_ok = push & (~full | pop);

  // Frame storage; emptiness is tracked by the pointers, not the contents.
  always_ff @(posedge serial_clk) begin
    if (push_ok) mem[wr_ptr] <= rx_sr;
  end

  // Pointers and registered fill level.
  always_ff @(posedge serial_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= fifo_level + LVW'(push_ok) - LVW'(pop);
    end
  end

  // ---------------- processing ----------------
  logic [FB-1:0]                  head;
  logic [CHANNELS-1:0][WIDTH-1:0] proc_frame, frame_q;

  assign head = mem[rd_ptr];

  // Channel 0 arrives first, so it sits in the top bits of the frame word.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    audio_chan_proc #(.WIDTH(WIDTH)) u_proc (
      .sample     (head[FB-1-k*WIDTH -: WIDTH]),
      .mute       (mute),
      .attenuation(attenuation),
      .result     (proc_frame[k])
    );
  end

  // ---------------- transmitter ----------------
  // Outputs are computed for the next position and registered together, so
  // bit number, word select and data always refer to the same position.
  logic [SW-1:0]    off_q, off_n;
  logic [KW-1:0]    slot_q, slot_n;
  logic [BNW-1:0]   bit_n;
  logic             ws_n, data_n, started;
  logic [WIDTH-1:0] ch_word;

  // Next slot/offset/bit position and the serial bit belonging to it.
  always_comb begin
    off_n  = off_q + SW'(1);
    slot_n = slot_q;
    bit_n  = i2s_bit_number + BNW'(1);
    if (off_q == SW'(SLOT_BITS-1)) begin
      off_n  = '0;
      slot_n = (slot_q == KW'(CHANNELS-1)) ? '0 : slot_q + KW'(1);
    end
    if (load) bit_n = '0;
    ws_n    = (bit_n >= BNW'(TOTAL/2));
    ch_word = frame_q[slot_n];
    data_n  = 1'b0;
    // One-bit delay after the slot start, then MSB first.
    if (off_n != '0 && int'(off_n) <= WIDTH)
      data_n = ch_word[IW'(WIDTH - int'(off_n))];
  end

  // Position counters, serial outputs and the frame being played.
  always_ff @(posedge serial_clk or negedge reset) begin
    if (!reset) begin
      i2s_bit_number    <= '0;
      off_q             <= '0;
      slot_q            <= '0;
      i2s_ws            <= 1'b0;
      i2s_sound_bit_out <= 1'b0;
      frame_q           <= '0;
      started           <= 1'b0;
    end else begin
      i2s_bit_number    <= bit_n;
      off_q             <= off_n;
      slot_q            <= slot_n;
      i2s_ws            <= ws_n;
      i2s_sound_bit_out <= data_n;
      if (load) begin
        frame_q <= pop ? proc_frame : '0;
        if (pop) started <= 1'b1;
      end
    end
  end

  // Sticky flags; a set event in the same cycle beats clear_flags.
  always_ff @(posedge serial_clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & full & ~pop) overflow <= 1'b1;
      else if (clear_flags)   overflow <= 1'b0;
      if (load & empty & started) underflow <= 1'b1;
      else if (clear_flags)       underflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_audio_stream_transceiver.sv
// Bench for audio_stream_transceiver: directed scenarios plus random traffic,
// compared every cycle against a frame-level queue model.
module tb_audio_stream_transceiver;
  localparam int W   = 16;
  localparam int CH  = 2;
  localparam int SB  = 32;
  localparam int D   = 4;
  localparam int TOTAL = CH*SB;
  localparam int FB  = CH*W;
  localparam int BNW = $clog2(TOTAL);
  localparam int LVW = $clog2(D+1);

  logic serial_clk = 0, rst_n = 0;
  logic spi_chip_select = 1, spi_mosi = 0, mute = 0, clear_flags = 0;
  logic [3:0] attenuation = 0;
  logic i2s_ws, i2s_sound_bit_out, overflow, underflow;
  logic [BNW-1:0] i2s_bit_number;
  logic [LVW-1:0] fifo_level;

  int total = 0, bad = 0;

  audio_stream_transceiver #(.WIDTH(W), .CHANNELS(CH), .SLOT_BITS(SB), .DEPTH(D)) dut (
    .serial_clk(serial_clk), .reset(rst_n), .spi_chip_select(spi_chip_select),
    .spi_mosi(spi_mosi), .mute(mute), .attenuation(attenuation), .clear_flags(clear_flags),
    .i2s_ws(i2s_ws), .i2s_sound_bit_out(i2s_sound_bit_out), .i2s_bit_number(i2s_bit_number),
    .fifo_level(fifo_level), .overflow(overflow), .underflow(underflow));

  always #5 serial_clk = ~serial_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef logic [CH-1:0][W-1:0] pf_t;
  pf_t        mq[$];
  logic [W-1:0] mfr [CH];
  pf_t        mrxw, mpend_f;
  int         mn, mrxc;
  bit         mstarted, mov, mun, mpend;

  function automatic logic [W-1:0] mproc(input logic [W-1:0] s, input logic m, input logic [3:0] a);
    int v, sh;
    if (m) return '0;
    v = int'(s);
    if (s[W-1]) v = v - (1 << W);
    sh = (int'(a) > W-1) ? W-1 : int'(a);
    v = v >>> sh;
    return v[W-1:0];
  endfunction

  task automatic mreset();
    mq.delete();
    mn = 0; mrxc = 0; mstarted = 0; mov = 0; mun = 0; mpend = 0;
    mrxw = '0; mpend_f = '0;
    for (int k = 0; k < CH; k++) mfr[k] = '0;
  endtask

  task automatic mstep();
    bit ld, popped, ovs, uns;
    int sz, k;
    pf_t h;
    ld = (mn == TOTAL-1); popped = 0; ovs = 0; uns = 0; sz = mq.size();
    if (ld) begin
      if (sz > 0) begin
        h = mq.pop_front();
        for (int c = 0; c < CH; c++) mfr[c] = mproc(h[c], mute, attenuation);
        popped = 1;
        mstarted = 1;
      end else begin
        for (int c = 0; c < CH; c++) mfr[c] = '0;
        if (mstarted) uns = 1;
      end
    end
    if (mpend) begin
      if (sz < D || popped) mq.push_back(mpend_f);
      else ovs = 1;
    end
    mpend = 0;
    if (!spi_chip_select) begin
      if (mrxc < FB) begin
        k = mrxc / W;
        mrxw[k] = {mrxw[k][W-2:0], spi_mosi};
        mrxc++;
        if (mrxc == FB) begin mpend = 1; mpend_f = mrxw; end
      end
    end else mrxc = 0;
    mov = ovs ? 1'b1 : (clear_flags ? 1'b0 : mov);
    mun = uns ? 1'b1 : (clear_flags ? 1'b0 : mun);
    mn = (mn + 1) % TOTAL;
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge serial_clk or negedge rst_n);
      if (!rst_n) mreset(); else mstep();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      logic ws_e, d_e;
      int k, p;
      @(negedge serial_clk);
      ws_e = (mn >= TOTAL/2);
      k = mn / SB; p = mn % SB;
      d_e = (p >= 1 && p <= W) ? mfr[k][W-p] : 1'b0;
      chk($sformatf("cycle n=%0d {ws,sd,n,lvl,ov,un}", mn),
          {i2s_ws, i2s_sound_bit_out, i2s_bit_number, fifo_level, overflow, underflow},
          {ws_e, d_e, BNW'(mn), LVW'(mq.size()), mov, mun});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_bits(input logic [FB-1:0] f, input int nbits, input int extra);
    for (int i = 0; i < nbits; i++) begin
      @(negedge serial_clk); spi_chip_select = 0; spi_mosi = f[FB-1-i];
    end
    for (int i = 0; i < extra; i++) begin
      @(negedge serial_clk); spi_mosi = 1'($urandom_range(0, 1));
    end
    @(negedge serial_clk); spi_chip_select = 1; spi_mosi = 0;
  endtask

  task automatic wait_n(input int v);
    int t;
    t = 0;
    while (int'(i2s_bit_number) != v && t < 2*TOTAL) begin @(negedge serial_clk); t++; end
    if (t >= 2*TOTAL) begin
      total++; bad++;
      $display("FAIL wait_n timeout: n=%0d want %0d", i2s_bit_number, v);
    end
  endtask

  // Capture the next played frame from the serial output.
  task automatic play_check(input logic [W-1:0] el, input logic [W-1:0] er, input string nm);
    logic [W-1:0] gl, gr;
    int n;
    gl = '0; gr = '0;
    wait_n(TOTAL-1);
    repeat (TOTAL) begin
      @(negedge serial_clk);
      n = int'(i2s_bit_number);
      if (n >= 1 && n <= W)           gl = {gl[W-2:0], i2s_sound_bit_out};
      if (n >= SB+1 && n <= SB+W)     gr = {gr[W-2:0], i2s_sound_bit_out};
    end
    chk({nm, " left"}, gl, el);
    chk({nm, " right"}, gr, er);
  endtask

  task automatic pulse_clear();
    @(negedge serial_clk); clear_flags = 1;
    @(negedge serial_clk); clear_flags = 0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Model pinning with hand-computed values.
    chk("mproc att2 0x8000", mproc(16'h8000, 0, 4'd2), 64'hE000);
    chk("mproc att15 0x8000", mproc(16'h8000, 0, 4'd15), 64'hFFFF);
    chk("mproc mute", mproc(16'h7FFF, 1, 4'd0), 64'h0);

    // 1. reset
    repeat (3) @(negedge serial_clk);
    chk("reset outputs", {i2s_ws, i2s_sound_bit_out, i2s_bit_number, fifo_level, overflow, underflow}, 0);
    @(posedge serial_clk); #2 rst_n = 1;
    @(negedge serial_clk); chk("n after release", i2s_bit_number, 0);
    @(negedge serial_clk); chk("n first count", i2s_bit_number, 1);
    send_bits(32'h1111_2222, FB, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge serial_clk); spi_chip_select = 0; spi_mosi = 1'($urandom_range(0, 1));
    end
    @(posedge serial_clk); #3 rst_n = 0;
    #1 chk("async reset outputs", {i2s_ws, i2s_sound_bit_out, i2s_bit_number, fifo_level, overflow, underflow}, 0);
    spi_chip_select = 1;
    @(negedge serial_clk);
    @(posedge serial_clk); #2 rst_n = 1;
    @(negedge serial_clk); chk("n after mid reset", i2s_bit_number, 0);
    @(negedge serial_clk); chk("n count after mid reset", i2s_bit_number, 1);
    wait_n(TOTAL-1); @(negedge serial_clk);
    chk("no underflow before first pop", underflow, 0);

    // 2. single frame
    send_bits(32'h8001_1234, FB, 0);
    @(negedge serial_clk); chk("level after push", fifo_level, 1);
    play_check(16'h8001, 16'h1234, "single frame");
    chk("level drained", fifo_level, 0);

    // 3. processing
    attenuation = 4'd2;
    send_bits(32'h8000_4000, FB, 0);
    play_check(16'hE000, 16'h1000, "att2");
    attenuation = 4'd15;
    send_bits(32'h8000_4000, FB, 0);
    play_check(16'hFFFF, 16'h0000, "att15");
    attenuation = 4'd0; mute = 1;
    send_bits(32'hFFFF_7FFF, FB, 0);
    play_check(16'h0000, 16'h0000, "mute");
    mute = 0;

    // 5. partial frame then full frame with trailing ignored bits
    send_bits(32'hDEAD_BEEF, 20, 0);
    @(negedge serial_clk); @(negedge serial_clk);
    chk("level after partial", fifo_level, 0);
    send_bits(32'hAAAA_5555, FB, 3);
    play_check(16'hAAAA, 16'h5555, "after partial");

    // 6. underflow and clear
    wait_n(10); pulse_clear();
    chk("underflow cleared", underflow, 0);
    wait_n(TOTAL-1); @(negedge serial_clk);
    chk("underflow set on empty load", underflow, 1);
    wait_n(10); pulse_clear();
    chk("underflow cleared again", underflow, 0);
    wait_n(TOTAL-1); clear_flags = 1;
    @(negedge serial_clk); clear_flags = 0;
    chk("set beats clear", underflow, 1);

    // 4. overflow burst
    wait_n(10); pulse_clear();
    chk("overflow clear", overflow, 0);
    for (int i = 0; i < 12; i++) send_bits(FB'($urandom), FB, 0);
    chk("overflow set", overflow, 1);
    repeat (6*TOTAL) @(negedge serial_clk);
    chk("level after drain", fifo_level, 0);

    // random traffic
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 70)) @(negedge serial_clk);
      if ($urandom_range(0, 4) == 0) begin
        attenuation = 4'($urandom_range(0, 15));
        mute = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 9) == 0) pulse_clear();
      if ($urandom_range(0, 7) == 0) send_bits(FB'($urandom), $urandom_range(1, FB-1), 0);
      else send_bits(FB'($urandom), FB, $urandom_range(0, 3));
    end
    mute = 0; attenuation = 0;
    repeat (6*TOTAL) @(negedge serial_clk);
    chk("final level", fifo_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/audio_stream_transceiver.md
Name: audio_stream_transceiver

Overview:
- Parametrised successor to the single-channel SPI-in / I2S-out audio path.
- Receives multi-channel PCM frames over an SPI-style serial input and buffers whole frames in a FIFO of DEPTH entries.
- Applies per-frame mute and attenuation, then streams the frames out as an I2S-style serial output.
- Adds overflow/underflow detection and a fill-level output for the upstream SPI master's flow control.

Parameters:
WIDTH, 16, sample width in bits, two's complement; WIDTH <= SLOT_BITS-1
CHANNELS, 2, channels per frame; even, 2..8
SLOT_BITS, 32, output clocks per channel slot
DEPTH, 4, FIFO depth in frames; power of two, >= 2

Ports:
serial_clk  in  1  single clock for all logic; everything samples on the rising edge
reset  in  1  asynchronous, active-low reset
spi_chip_select  in  1  active-low frame enable
spi_mosi  in  1  serial data, MSB first, channel 0 first
mute  in  1  forces output samples to 0
attenuation  in  4  arithmetic right shift applied to samples
clear_flags  in  1  clears the sticky flags
i2s_ws  out  1  word select
i2s_sound_bit_out  out  1  serial output data
i2s_bit_number  out  $clog2(CHANNELS*SLOT_BITS)  output bit position within the frame
fifo_level  out  $clog2(DEPTH+1)  frames held in the FIFO
overflow  out  1  sticky: a received frame was dropped
underflow  out  1  sticky: the FIFO was empty at a frame load

Behaviour:
- Definitions: FRAME_BITS = CHANNELS*WIDTH; TOTAL = CHANNELS*SLOT_BITS.
- Reset (reset=0, asynchronous): every output = 0; receive counter = 0; FIFO emptied; frame register = 0; started = 0.

Receiver:
- While spi_chip_select=0: shift spi_mosi in each cycle and increment the receive counter.
- When the counter reaches FRAME_BITS, the frame is complete. Push is attempted on the next cycle.
- Further bits received while cs stays low are ignored.
- spi_chip_select=1 holds the counter at 0. A rising cs with a partial count discards the partial frame (no push, no flag).
- Consecutive frames require cs high for at least 1 cycle between them.

FIFO:
- Push when not full. Push while full: frame dropped, overflow <= 1.
- Push and pop in the same cycle while full: both succeed, level unchanged.
- Push and pop in the same cycle while empty: the pop sees empty and the pushed frame is stored; there is no bypass.
- fifo_level is registered and updates the cycle after the push or pop.

Transmitter:
- Bit counter free-runs 0..TOTAL-1 and wraps; i2s_bit_number = counter.
- Frame load happens on the cycle the counter = TOTAL-1:
  - If the FIFO is non-empty: pop the head and set started <= 1.
  - If the FIFO is empty: load zeros. Set underflow <= 1 only if started = 1; before the first pop, silence produces no flag.
- Processing is applied at load, per channel:
  - out = 0 if mute = 1;
  - otherwise out = sample >>> min(attenuation, WIDTH-1), sign-extended.
  - mute and attenuation are sampled only at load and stay constant for the whole frame.
- The registered outputs are mutually consistent: in the cycle where i2s_bit_number = n, i2s_ws and i2s_sound_bit_out both belong to position n.
- i2s_ws = 0 for n < TOTAL/2 and 1 otherwise.
- Slot k = n / SLOT_BITS, offset p = n mod SLOT_BITS.
  - Data bit is frame channel k bit (WIDTH-p) for 1 <= p <= WIDTH (one-bit I2S delay, MSB first).
  - Data bit is 0 at p = 0 and for p > WIDTH.

Flags:
- clear_flags = 1 clears overflow and underflow on the next edge.
- A set event in the same cycle as clear_flags wins, so the flag reads 1.
- Reset applied mid-frame aborts both receive and transmit; the bit counter restarts at 0 on the first clock after release.

Test Plan:
1. Reset: pull reset low mid-stream, asynchronous to serial_clk -> all outputs 0 immediately; fifo_level=0; after release the counter counts up from 0 and output is zeros with underflow=0.
2. Single frame (defaults): send L=0x8001, R=0x1234 -> fifo_level=1 two cycles after the 32nd bit; after the next wrap, n=1..16 carries 1000000000000001 with ws=0, n=33..48 carries 0x1234 MSB-first with ws=1; fifo_level returns to 0.
3. Processing: attenuation=2 with L=0x8000, R=0x4000 -> transmitted 0xE000, 0x1000. attenuation=15 with WIDTH=16 -> 0xFFFF, 0x0000. mute=1 -> all data bits 0.
4. Overflow: with WIDTH=8, CHANNELS=2, DEPTH=2, start right after a wrap and send 3 frames of 16 bits + 1 cs-high cycle each (51 cycles < 64) -> third frame dropped, overflow=1, fifo_level=2; the first two frames play in order.
5. Partial frame: raise cs after 20 of 32 bits -> no push, fifo_level unchanged; the next full frame (0xAAAA, 0x5555) is received and played correctly.
6. Underflow and clear: play one frame, then send nothing -> the next frame outputs zeros and underflow=1. Pulse clear_flags -> underflow=0 until the next empty load sets it again. clear_flags in the same cycle as an empty load -> underflow stays 1.
